mbist_resp_analyzer: RTL
========================

# mbist_resp_analyzer

Read-side response analyzer for the MBIST SRAM engine. It is the consumer at the far end of the address stream that `addr_gen` produces. It tracks each issued SRAM read through a configurable read-latency pipeline and compares the returned word against the expected pattern. It records the first failing address and syndrome, counts failures, and reports PASS/DONE once the address sweep has ended and the pipeline has drained.

## Interface
- `ADDR_WIDTH`, default 7: width of the address tagged to each read.
- `DATA_WIDTH`, default 8: SRAM word width.
- `RD_LATENCY`, default 1 (legal range 1..4): SRAM read latency, measured in clock edges.
- `CNT_WIDTH`, default 8: width of the fail counter.
- `CLK` input, 1 bit: single clock; every register updates on the rising edge.
- `RESET` input, 1 bit: synchronous, active-high reset.
- `MBISTEN` input, 1 bit: test enable; level-sensitive.
- `RD_EN` input, 1 bit: a read is issued this cycle.
- `ADDR` input, `ADDR_WIDTH` bits: address of the issued read.
- `EXP_DATA` input, `DATA_WIDTH` bits: expected word for the issued read.
- `Q` input, `DATA_WIDTH` bits: SRAM read data.
- `ADDR_done` input, 1 bit: end-of-sweep indication from the address generator.
- `FAIL` output, 1 bit: sticky; set on any mismatch.
- `FAIL_ADDR` output, `ADDR_WIDTH` bits: address of the first mismatch.
- `FAIL_BITS` output, `DATA_WIDTH` bits: `Q ^ EXP_DATA` of the first mismatch.
- `FAIL_CNT` output, `CNT_WIDTH` bits: number of mismatches, saturating.
- `DONE` output, 1 bit: analysis complete.
- `PASS` output, 1 bit: equals `DONE & ~FAIL`.

## Operation
- Reset values: all outputs 0, state IDLE, pipeline valid bits 0.
- The FSM has four states: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN when `MBISTEN`=1. This transition clears `FAIL`, `FAIL_ADDR`, `FAIL_BITS` and `FAIL_CNT`.
- RUN: a read is accepted when `RD_EN`=1, which pushes {valid, `ADDR`, `EXP_DATA`} into a pipeline `RD_LATENCY` stages deep.
- RUN -> DRAIN when `ADDR_done`=1 is sampled. If `RD_EN` is high in that same cycle, that read is still accepted.
- DRAIN: `RD_EN` is ignored. Entering DRAIN loads the drain counter with `RD_LATENCY`, and the counter decrements every DRAIN cycle. When DRAIN sees the counter at 0, the FSM moves to DONE.
- DONE: `DONE`=1 and `PASS`=`~FAIL`. The FSM stays in DONE while `MBISTEN`=1 and moves to IDLE when `MBISTEN`=0. `DONE` clears on that exit; the fail results are held until the next start.
- `MBISTEN`=0 in RUN or DRAIN: go to IDLE at the next edge and flush all pipeline valid bits. `DONE` stays 0 and the fail results are held.
- Compare rule: when the pipeline tail valid bit is set, `Q` is compared with the tail expected word.
  - On mismatch, `FAIL` is set and `FAIL_CNT` increments, saturating at 2^`CNT_WIDTH`-1.
  - `FAIL_ADDR` and `FAIL_BITS` are captured only while `FAIL` is still 0, so later mismatches never overwrite them.
- Reads are compared in both RUN and DRAIN. No compare happens in IDLE or DONE.
- `RESET` takes priority over every other event in every state.

## Timing
- A read accepted at edge k has its `Q` sampled and compared at edge k+`RD_LATENCY`. `FAIL`, `FAIL_CNT`, `FAIL_ADDR` and `FAIL_BITS` are visible immediately after that edge.
- `ADDR_done` sampled at edge d:
  - DRAIN is entered at d.
  - The last read is compared at d+`RD_LATENCY`.
  - `DONE` and `PASS` go high after edge d+`RD_LATENCY`+1.
- Back-to-back reads are supported every cycle with no bubbles.
- `ADDR_done` is treated as level-sampled in RUN only, so a multi-cycle high is harmless.
- If a mismatch and a saturated counter occur together, the counter holds its value and `FAIL` remains 1.

## Test plan
- Apply `RESET` for 3 cycles with random inputs -> all outputs 0; `RESET` during RUN returns the block to IDLE at the next edge.
- `RD_LATENCY`=1, 128 reads to addresses 0..127 with `Q`=`EXP_DATA`=0x55, `ADDR_done` at the last read -> `DONE`=`PASS`=1 exactly 2 edges after `ADDR_done`; `FAIL_CNT`=0.
- Same sweep with `Q`=0x5D at address 0x2A -> `FAIL`=1, `FAIL_ADDR`=0x2A, `FAIL_BITS`=0x08, `FAIL_CNT`=1, `PASS`=0.
- Faults at 0x10 (syndrome 0x01) then 0x70 (syndrome 0x80) -> `FAIL_ADDR`=0x10, `FAIL_BITS`=0x01, `FAIL_CNT`=2.
- `CNT_WIDTH`=4 with 20 mismatching reads -> `FAIL_CNT`=15, holding at 15.
- `RD_LATENCY`=3, with a mismatch on the read issued together with `ADDR_done` -> the mismatch is caught in DRAIN; `DONE` rises 4 edges after `ADDR_done`. Then drop `MBISTEN` mid-RUN on a second run -> IDLE, `DONE`=0, results held; re-enable -> results cleared.

Source files
------------

// File: rtl/mbist_resp_analyzer.sv
// MBIST read-side response analyzer: tracks issued SRAM reads through a read-latency
// pipeline, compares returned data to the expected word, and records fail results.
module mbist_resp_analyzer #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  MBISTEN,
  input  logic                  RD_EN,
  input  logic [ADDR_WIDTH-1:0] ADDR,
  input  logic [DATA_WIDTH-1:0] EXP_DATA,
  input  logic [DATA_WIDTH-1:0] Q,
  input  logic                  ADDR_done,
  output logic                  FAIL,
  output logic [ADDR_WIDTH-1:0] FAIL_ADDR,
  output logic [DATA_WIDTH-1:0] FAIL_BITS,
  output logic [CNT_WIDTH-1:0]  FAIL_CNT,
  output logic                  DONE,
  output logic                  PASS,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] DRAIN_INIT = 3'(RD_LATENCY);

  state_t state, state_nxt;
  logic [2:0] drain_cnt;

  logic [RD_LATENCY-1:0]                 pipe_vld;
  logic [RD_LATENCY-1:0][ADDR_WIDTH-1:0] pipe_addr;
  logic [RD_LATENCY-1:0][DATA_WIDTH-1:0] pipe_exp;

  logic accept, cmp_en, start, flush, mism;
  logic [DATA_WIDTH-1:0] syndrome;

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; dropping MBISTEN aborts any active sweep
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (MBISTEN) state_nxt = S_RUN;
      S_RUN:   if (!MBISTEN) state_nxt = S_IDLE;
               else if (ADDR_done) state_nxt = S_DRAIN;
      S_DRAIN: if (!MBISTEN) state_nxt = S_IDLE;
               else if (drain_cnt == 3'd0) state_nxt = S_DONE;
      S_DONE:  if (!MBISTEN) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    accept    = (state == S_RUN) && MBISTEN && RD_EN;
    cmp_en    = ((state == S_RUN) || (state == S_DRAIN)) && MBISTEN && pipe_vld[RD_LATENCY-1];
    start     = (state == S_IDLE) && MBISTEN;
    flush     = ((state == S_RUN) || (state == S_DRAIN)) && !MBISTEN;
    DONE      = (state == S_DONE);
    PASS      = DONE & ~FAIL;
    dbg_state = state;
  end

  // Drain counter covers the reads still in flight when the sweep ends
  always_ff @(posedge CLK) begin
    if (RESET)                                         drain_cnt <= 3'd0;
    else if ((state == S_RUN) && (state_nxt == S_DRAIN)) drain_cnt <= DRAIN_INIT;
    else if ((state == S_DRAIN) && (drain_cnt != 3'd0))  drain_cnt <= drain_cnt - 3'd1;
  end

  always_ff @(posedge CLK) begin
    if (RESET || flush) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= accept;
      for (int i = 1; i < RD_LATENCY; i++) pipe_vld[i] <= pipe_vld[i-1];
    end
  end

  // Payload only matters when its valid bit is set, so it carries no reset
  always_ff @(posedge CLK) begin
    pipe_addr[0] <= ADDR;
    pipe_exp[0]  <= EXP_DATA;
    for (int i = 1; i < RD_LATENCY; i++) begin
      pipe_addr[i] <= pipe_addr[i-1];
      pipe_exp[i]  <= pipe_exp[i-1];
    end
  end

  assign syndrome = Q ^ pipe_exp[RD_LATENCY-1];
  assign mism     = cmp_en && (syndrome != '0);

  // First-fail capture is locked once FAIL is set; the count saturates
  always_ff @(posedge CLK) begin
    if (RESET || start) begin
      FAIL      <= 1'b0;
      FAIL_ADDR <= '0;
      FAIL_BITS <= '0;
      FAIL_CNT  <= '0;
    end else if (mism) begin
      FAIL <= 1'b1;
      if (!FAIL) begin
        FAIL_ADDR <= pipe_addr[RD_LATENCY-1];
        FAIL_BITS <= syndrome;
      end
      if (FAIL_CNT != '1) FAIL_CNT <= FAIL_CNT + CNT_WIDTH'(1);
    end
  end

endmodule
